// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU op/sel codes, divider states and
// the divider request/response structs. The divider is built only with EX_DIV_EN.
package ex_stage_pkg;

    localparam int ALU_OP_W   = 8;
    localparam int ALU_SEL_W  = 3;
    localparam int REG_ADDR_W = 5;
    localparam int DIV_W      = 32;

    localparam logic [ALU_OP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [ALU_OP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [ALU_OP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [ALU_OP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [ALU_OP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [ALU_OP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [ALU_OP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [ALU_OP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [ALU_OP_W-1:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [ALU_OP_W-1:0] EXE_SLTU_OP = 8'b0010_1011;
    localparam logic [ALU_OP_W-1:0] EXE_ADDU_OP = 8'b0010_0001;
    localparam logic [ALU_OP_W-1:0] EXE_SUBU_OP = 8'b0010_0011;
    localparam logic [ALU_OP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam logic [ALU_SEL_W-1:0] EXE_RES_NOP        = 3'b000;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_ARITHMETIC = 3'b011;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_SHIFT      = 3'b100;

    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    typedef struct packed {
        logic             start;
        logic             sign;
        logic             annul;
        logic [DIV_W-1:0] op1;
        logic [DIV_W-1:0] op2;
    } div_req_t;

    typedef struct packed {
        logic               ready;
        logic [2*DIV_W-1:0] result;   // {remainder, quotient}
    } div_rsp_t;

    function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Sequential 32-iteration restoring divider with signed fix-up and
// divide-by-zero short path; start must be held until ready.
module ex_stage_div
    import ex_stage_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  div_req_t req,
    output div_rsp_t rsp
);

    logic [1:0]         state;
    logic [5:0]         cnt;
    logic [2*DIV_W-1:0] acc;      // {partial remainder, dividend/quotient}
    logic [DIV_W-1:0]   divisor;
    logic               neg_q;
    logic               neg_r;

    logic [DIV_W-1:0]   op1_mag;
    logic [DIV_W-1:0]   op2_mag;
    logic [DIV_W+1:0]   diff;
    logic               abort;
    logic [DIV_W-1:0]   quo;
    logic [DIV_W-1:0]   rem;

    assign op1_mag = (req.sign && req.op1[DIV_W-1]) ? -req.op1 : req.op1;
    assign op2_mag = (req.sign && req.op2[DIV_W-1]) ? -req.op2 : req.op2;
    assign abort   = req.annul || !req.start;

    // Trial subtract of the divisor from the next 33-bit partial remainder.
    assign diff = {1'b0, acc[2*DIV_W-1:DIV_W-1]} - {2'b00, divisor};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DivFree;
            cnt     <= '0;
            acc     <= '0;
            divisor <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            case (state)
                DivFree: begin
                    if (req.start && !req.annul) begin
                        divisor <= op2_mag;
                        cnt     <= '0;
                        if (req.op2 == '0) begin
                            state <= DivByZero;
                            acc   <= {req.op1, {DIV_W{1'b1}}};
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end else begin
                            state <= DivOn;
                            acc   <= {{DIV_W{1'b0}}, op1_mag};
                            neg_q <= req.sign && (req.op1[DIV_W-1] ^ req.op2[DIV_W-1]);
                            neg_r <= req.sign && req.op1[DIV_W-1];
                        end
                    end
                end
                DivByZero: state <= abort ? DivFree : DivEnd;
                DivOn: begin
                    if (abort) begin
                        state <= DivFree;
                    end else begin
                        acc <= diff[DIV_W+1] ? {acc[2*DIV_W-2:0], 1'b0}
                                             : {diff[DIV_W-1:0], acc[DIV_W-2:0], 1'b1};
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) state <= DivEnd;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

    assign quo = acc[DIV_W-1:0];
    assign rem = acc[2*DIV_W-1:DIV_W];

    always_comb begin
        rsp.ready  = (state == DivEnd) ? DivResultReady : DivResultNotReady;
        rsp.result = {(neg_r ? -rem : rem), (neg_q ? -quo : quo)};
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU paths plus an optional multi-cycle divider
// (present only when EX_DIV_EN is defined) that stalls the pipeline while busy.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALU_OP_W-1:0]   aluOp_i,
    input  logic [ALU_SEL_W-1:0]  aluSel_i,
    input  logic [DATA_W-1:0]     reg1_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  whilo_o,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic                  stallreq_o
);

    logic              is_div;
    logic [DATA_W-1:0] logic_res;
    logic [DATA_W-1:0] shift_res;
    logic [DATA_W-1:0] arith_res;
    logic [DATA_W-1:0] alu_res;
    logic              div_busy;
    logic              div_done;
    logic [DATA_W-1:0] div_hi;
    logic [DATA_W-1:0] div_lo;

    assign is_div = is_div_op(aluOp_i);

    always_comb begin
        logic_res = '0;
        case (aluOp_i)
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            default:    logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (aluOp_i)
            EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
            EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
            EXE_SRA_OP: shift_res = DATA_W'($signed(reg2_i) >>> reg1_i[4:0]);
            default:    shift_res = '0;
        endcase
    end

    always_comb begin
        arith_res = '0;
        case (aluOp_i)
            EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
            EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
            EXE_SLT_OP:  arith_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
            EXE_SLTU_OP: arith_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
            default:     arith_res = '0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (aluSel_i)
            EXE_RES_LOGIC:      alu_res = logic_res;
            EXE_RES_SHIFT:      alu_res = shift_res;
            EXE_RES_ARITHMETIC: alu_res = arith_res;
            default:            alu_res = '0;
        endcase
    end

`ifdef EX_DIV_EN
    div_req_t div_req;
    div_rsp_t div_rsp;

    always_comb begin
        div_req.start = is_div ? DivStart : DivStop;
        div_req.sign  = (aluOp_i == EXE_DIV_OP);
        div_req.annul = flush_i;
        div_req.op1   = reg1_i;
        div_req.op2   = reg2_i;
    end

    ex_stage_div u_div (
        .clk (clk),
        .rst (rst),
        .req (div_req),
        .rsp (div_rsp)
    );

    assign div_done = is_div && (div_rsp.ready == DivResultReady);
    assign div_busy = is_div && (div_rsp.ready != DivResultReady);
    assign div_hi   = div_rsp.result[2*DIV_W-1:DIV_W];
    assign div_lo   = div_rsp.result[DIV_W-1:0];
`else
    // Divides decode as NOP; clock and flush have no consumer in this build.
    logic unused_div_ports;
    assign unused_div_ports = clk ^ flush_i;
    assign div_done = 1'b0;
    assign div_busy = 1'b0;
    assign div_hi   = '0;
    assign div_lo   = '0;
`endif

    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = 1'b0;
        if (!rst) begin
            wd_o       = wd_i;
            wreg_o     = wreg_i && !is_div;
            wdata_o    = alu_res;
            whilo_o    = div_done;
            hi_o       = div_done ? div_hi : '0;
            lo_o       = div_done ? div_lo : '0;
            stallreq_o = div_busy;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: arithmetic reference model checked every cycle
// plus literal expectations at the key points; adapts to EX_DIV_EN.
module tb_ex_stage;
    import ex_stage_pkg::*;

`ifdef EX_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [ALU_OP_W-1:0]   aluOp_i;
    logic [ALU_SEL_W-1:0]  aluSel_i;
    logic [31:0]           reg1_i;
    logic [31:0]           reg2_i;
    logic [REG_ADDR_W-1:0] wd_i;
    logic                  wreg_i;
    logic                  flush_i;
    logic [REG_ADDR_W-1:0] wd_o;
    logic                  wreg_o;
    logic [31:0]           wdata_o;
    logic                  whilo_o;
    logic [31:0]           hi_o;
    logic [31:0]           lo_o;
    logic                  stallreq_o;

    int checks = 0;
    int fails  = 0;
    int age    = 0;   // cycles the current divide has been held

    ex_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .aluOp_i(aluOp_i), .aluSel_i(aluSel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            EXE_OR_OP:   return a | b;
            EXE_AND_OP:  return a & b;
            EXE_XOR_OP:  return a ^ b;
            EXE_NOR_OP:  return ~(a | b);
            EXE_ADDU_OP: return a + b;
            EXE_SUBU_OP: return a - b;
            EXE_SLT_OP:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            EXE_SLTU_OP: return (a < b) ? 32'd1 : 32'd0;
            EXE_SLL_OP:  return b << a[4:0];
            EXE_SRL_OP:  return b >> a[4:0];
            EXE_SRA_OP:  return 32'($signed(b) >>> a[4:0]);
            default:     return 32'd0;
        endcase
    endfunction

    // {hi, lo} from plain 64-bit integer division (truncating, C-style remainder).
    function automatic logic [63:0] div_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        x = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        y = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int div_last(input logic [31:0] b);
        return (b == 32'd0) ? 2 : 33;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wd, input logic wr);
        aluOp_i  = op;
        aluSel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = wd;
        wreg_i   = wr;
    endtask

    always @(posedge clk) begin
        if (rst || flush_i || !is_div_op(aluOp_i) || age == div_last(reg2_i)) age <= 0;
        else age <= age + 1;
    end

    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int last;
        last = div_last(b);
        drive(op, EXE_RES_NOP, a, b, 5'd3, 1'b1);
        flush_i = 1'b0;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            chk("div_stall", 32'(stallreq_o), 32'((c < last) && DIV_EN));
            chk("div_whilo", 32'(whilo_o), 32'((c == last) && DIV_EN));
            if (c == last) begin
                chk("div_lo", lo_o, DIV_EN ? exp_lo : 32'd0);
                chk("div_hi", hi_o, DIV_EN ? exp_hi : 32'd0);
            end
            step();
        end
    endtask

    logic [7:0]  v_op [11] = '{EXE_OR_OP, EXE_SRA_OP, EXE_SLT_OP, EXE_SLTU_OP, EXE_ADDU_OP,
                               EXE_SUBU_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP};
    logic [2:0]  v_sel[11] = '{EXE_RES_LOGIC, EXE_RES_SHIFT, EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC,
                               EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC, EXE_RES_LOGIC, EXE_RES_LOGIC,
                               EXE_RES_LOGIC, EXE_RES_SHIFT, EXE_RES_SHIFT};
    logic [31:0] v_a  [11] = '{32'hF0F0_0000, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd1, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'd0, 32'd8, 32'd31};
    logic [31:0] v_b  [11] = '{32'h0000_0F0F, 32'h8000_0000, 32'd1, 32'd1, 32'd2,
                               32'd2, 32'hFF00_FF00, 32'hFF00_FF00, 32'd0, 32'd1, 32'h8000_0000};
    logic [31:0] v_exp[11] = '{32'hF0F0_0F0F, 32'hF800_0000, 32'd1, 32'd0, 32'd1,
                               32'hFFFF_FFFF, 32'hF000_F000, 32'h0FF0_0FF0, 32'hFFFF_FFFF, 32'h100, 32'd1};

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);

        // Per-cycle reference comparison of every output.
        fork
            forever begin
                logic        isd, whilo_e, stall_e;
                logic [63:0] dr;
                @(negedge clk);
                isd     = is_div_op(aluOp_i);
                whilo_e = !rst && DIV_EN && isd && (age == div_last(reg2_i));
                stall_e = !rst && DIV_EN && isd && (age != div_last(reg2_i));
                dr      = div_ref(aluOp_i == EXE_DIV_OP, reg1_i, reg2_i);
                chk("m_wd",    32'(wd_o),    rst ? 32'd0 : 32'(wd_i));
                chk("m_wreg",  32'(wreg_o),  32'(!rst && wreg_i && !isd));
                chk("m_wdata", wdata_o, (rst || aluSel_i == EXE_RES_NOP) ? 32'd0 : alu_ref(aluOp_i, reg1_i, reg2_i));
                chk("m_whilo", 32'(whilo_o), 32'(whilo_e));
                chk("m_stall", 32'(stallreq_o), 32'(stall_e));
                if (rst || whilo_e || !DIV_EN) begin
                    chk("m_lo", lo_o, whilo_e ? dr[31:0]  : 32'd0);
                    chk("m_hi", hi_o, whilo_e ? dr[63:32] : 32'd0);
                end
            end
        join_none

        // Reset forces zero outputs even with live inputs.
        drive(EXE_OR_OP, EXE_RES_LOGIC, 32'hF0F0_0000, 32'h0000_0F0F, 5'd5, 1'b1);
        @(negedge clk);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_wd", 32'(wd_o), 32'd0);
        chk("rst_wreg", 32'(wreg_o), 32'd0);
        step();
        drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd5, 1'b1);
        @(negedge clk);
        chk("rst_stall", 32'(stallreq_o), 32'd0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(v_op[i], v_sel[i], v_a[i], v_b[i], 5'd5, 1'b1);
            @(negedge clk);
            chk("alu_wdata", wdata_o, v_exp[i]);
            chk("alu_wd", 32'(wd_o), 32'd5);
            chk("alu_stall", 32'(stallreq_o), 32'd0);
            step();
        end

        run_div(EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 32'd2);
        run_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div(EXE_DIVU_OP, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        run_div(EXE_DIVU_OP, 32'd1000, 32'd3, 32'd333, 32'd1);

        // Flush at cycle 10 abandons the divide; the retry takes the full latency.
        drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd200, 32'd9, 5'd3, 1'b1);
        for (int c = 0; c < 10; c++) step();
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_whilo", 32'(whilo_o), 32'd0);
        step();
        run_div(EXE_DIVU_OP, 32'd200, 32'd9, 32'd22, 32'd2);

        // Reset at cycle 5, then a fresh divide.
        drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd200, 32'd9, 5'd3, 1'b1);
        for (int c = 0; c < 5; c++) step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_stall", 32'(stallreq_o), 32'd0);
        chk("mid_rst_whilo", 32'(whilo_o), 32'd0);
        chk("mid_rst_wd", 32'(wd_o), 32'd0);
        step();
        rst = 1'b0;
        run_div(EXE_DIVU_OP, 32'd50, 32'd6, 32'd8, 32'd2);

        // A non-divide op mid-divide also abandons it.
        drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd77, 32'd5, 5'd3, 1'b1);
        for (int c = 0; c < 5; c++) step();
        drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_00F0, 32'h0000_000F, 5'd7, 1'b1);
        @(negedge clk);
        chk("abort_or", wdata_o, 32'h0000_00FF);
        step();
        run_div(EXE_DIVU_OP, 32'd77, 32'd5, 32'd15, 32'd2);

        drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
